// File: rtl/seq_div4.sv
// seq_div4: 4-bit unsigned restoring divider, one step per cycle.
// Optional div0 flag port under `define DIV_ZERO_FLAG_EN.
module seq_div4 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       ready,
  output logic [3:0] Quot,
  output logic [3:0] Rem,
  output logic       out_valid,
  input  logic       out_ready
`ifdef DIV_ZERO_FLAG_EN
  ,
  output logic       div0
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [3:0] a_q;
  logic [3:0] b_q;
  logic [3:0] rem_q;
  logic [3:0] qw_q;
  logic [1:0] cnt_q;
  logic [3:0] quot_q;
  logic [3:0] remo_q;

  logic [4:0] shifted;
  logic       nob;
  logic [3:0] rem_n;
  logic       last;

  // one restoring step: shift in next dividend bit, subtract if no borrow
  always_comb begin
    shifted = {rem_q, a_q[3]};
    nob     = shifted >= {1'b0, b_q};
    rem_n   = nob ? (shifted[3:0] - b_q) : shifted[3:0];
    last    = cnt_q == 2'd3;
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // operand capture, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      rem_q  <= '0;
      qw_q   <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      remo_q <= '0;
    end else begin
      unique case (1'b1)
        state_q == IDLE && start: begin
          a_q   <= A;
          b_q   <= B;
          rem_q <= '0;
          qw_q  <= '0;
          cnt_q <= '0;
        end
        state_q == BUSY: begin
          a_q   <= {a_q[2:0], 1'b0};
          rem_q <= rem_n;
          qw_q  <= {qw_q[2:0], nob};
          cnt_q <= cnt_q + 2'd1;
          if (last) begin
            quot_q <= {qw_q[2:0], nob};
            remo_q <= rem_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready     = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign Quot      = quot_q;
  assign Rem       = remo_q;

`ifdef DIV_ZERO_FLAG_EN
  logic div0_q;

  // divisor-zero flag captured with the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      div0_q <= 1'b0;
    else if (state_q == IDLE && start) div0_q <= B == 4'd0;
  end

  assign div0 = div0_q & out_valid;
`endif

endmodule

// File: tb/tb_seq_div4.sv
// tb_seq_div4: table vectors, corner sequences and full sweep
// with a result scoreboard for seq_div4.
module tb_seq_div4;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] A;
  logic [3:0] B;
  logic       ready;
  logic [3:0] Quot;
  logic [3:0] Rem;
  logic       out_valid;
  logic       out_ready;
  logic       div0;

  seq_div4 dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .A(A),
    .B(B),
    .ready(ready),
    .Quot(Quot),
    .Rem(Rem),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef DIV_ZERO_FLAG_EN
    ,
    .div0(div0)
`endif
  );

`ifndef DIV_ZERO_FLAG_EN
  assign div0 = 1'b0;
`endif

  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       d;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  exp_t sbq[$];
  vec_t tbl[10];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  logic prev_ov = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input logic ok, input string nm,
                     input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // result monitor: latency on rising out_valid, scoreboard pop on handshake
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov)
        chk(cyc - acc_cyc == 5, "latency", cyc - acc_cyc, 5);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk(1'b0, "unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk(Quot == e.q, "quot", Quot, e.q);
          chk(Rem == e.r, "rem", Rem, e.r);
`ifdef DIV_ZERO_FLAG_EN
          chk(div0 == e.d, "div0", div0, e.d);
`endif
        end
      end
`ifdef DIV_ZERO_FLAG_EN
      if (!out_valid) chk(div0 == 1'b0, "div0_idle", div0, 0);
`endif
      prev_ov = out_valid;
    end
  end

  task automatic do_req(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] q, input logic [3:0] r,
                        input bit gap);
    int n;
    exp_t e;
    n = 0;
    while (!ready && n < 20) begin
      tick();
      n++;
    end
    if (!ready) begin
      chk(1'b0, "ready_timeout", 0, 1);
    end else begin
      if (gap) chk(cyc - acc_cyc == 6, "start_gap", cyc - acc_cyc, 6);
      start = 1'b1;
      A = a;
      B = b;
      e.q = q;
      e.r = r;
      e.d = b == 4'd0;
      sbq.push_back(e);
      acc_cyc = cyc;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk(sbq.size() == 0, "drain", sbq.size(), 0);
  endtask

  initial begin
    int n;
    int seen;
    tbl[0] = '{4'd13, 4'd4, 4'd3, 4'd1};
    tbl[1] = '{4'd15, 4'd1, 4'd15, 4'd0};
    tbl[2] = '{4'd3, 4'd9, 4'd0, 4'd3};
    tbl[3] = '{4'd7, 4'd0, 4'hF, 4'd7};
    tbl[4] = '{4'd0, 4'd5, 4'd0, 4'd0};
    tbl[5] = '{4'd15, 4'd15, 4'd1, 4'd0};
    tbl[6] = '{4'd14, 4'd3, 4'd4, 4'd2};
    tbl[7] = '{4'd8, 4'd8, 4'd1, 4'd0};
    tbl[8] = '{4'd0, 4'd0, 4'hF, 4'd0};
    tbl[9] = '{4'd11, 4'd2, 4'd5, 4'd1};

    rst_n = 1'b0;
    start = 1'b0;
    out_ready = 1'b0;
    A = '0;
    B = '0;
    tick();
    tick();
    chk(ready == 1'b1, "rst_ready", ready, 1);
    chk(out_valid == 1'b0, "rst_valid", out_valid, 0);
    chk(Quot == 4'd0, "rst_quot", Quot, 0);
    chk(Rem == 4'd0, "rst_rem", Rem, 0);
    rst_n = 1'b1;
    out_ready = 1'b1;

    for (int i = 0; i < 10; i++)
      do_req(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, 1'b0);
    drain();

    // start during BUSY ignored, result held while out_ready low
    out_ready = 1'b0;
    do_req(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    chk(ready == 1'b0, "busy_ready", ready, 0);
    start = 1'b1;
    A = 4'd1;
    B = 4'd1;
    tick();
    tick();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk(out_valid == 1'b1, "done_timeout", out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      chk(Quot == 4'd4, "hold_quot", Quot, 4);
      chk(Rem == 4'd1, "hold_rem", Rem, 1);
      chk(out_valid == 1'b1, "hold_valid", out_valid, 1);
      chk(ready == 1'b0, "hold_ready", ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk(out_valid == 1'b0, "release_valid", out_valid, 0);
    chk(ready == 1'b1, "release_ready", ready, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      tick();
    end
    chk(seen == 0, "no_queued_op", seen, 0);

    // reset in the second BUSY cycle discards the operation
    start = 1'b1;
    A = 4'd12;
    B = 4'd5;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk(ready == 1'b1, "midrst_ready", ready, 1);
    chk(out_valid == 1'b0, "midrst_valid", out_valid, 0);
    chk(Quot == 4'd0, "midrst_quot", Quot, 0);
    chk(Rem == 4'd0, "midrst_rem", Rem, 0);
    chk(div0 == 1'b0, "midrst_div0", div0, 0);
    tick();
    rst_n = 1'b1;
    chk(ready == 1'b1, "postrst_ready", ready, 1);
    do_req(4'd6, 4'd3, 4'd2, 4'd0, 1'b0);
    drain();

    // exhaustive sweep, back to back
    for (int i = 0; i < 256; i++) begin
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] q;
      logic [3:0] r;
      a = 4'(i >> 4);
      b = 4'(i);
      q = (b == 4'd0) ? 4'hF : a / b;
      r = (b == 4'd0) ? a : a % b;
      do_req(a, b, q, r, i > 0);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
